// File: rtl/led_fader_pkg.sv
// Shared encodings and constants for the LED fader and its PWM generator.
package led_fader_pkg;

    localparam int unsigned PWM_W  = 8;
    localparam int unsigned DUTY_W = PWM_W + 1;
    localparam int unsigned CALC_W = PWM_W + 2;

    localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(1 << PWM_W);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_BLINK = 2'b01,
        MODE_FADE  = 2'b10,
        MODE_HOLD  = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_BLINK   = 3'd1,
        S_UP      = 3'd2,
        S_HOLD_HI = 3'd3,
        S_DOWN    = 3'd4,
        S_HOLD_LO = 3'd5,
        S_HOLD    = 3'd6
    } state_e;

    typedef struct packed {
        state_e              state;
        logic [DUTY_W-1:0]   duty;
    } entry_t;

    // State and duty a mode starts from when it is newly selected.
    function automatic entry_t mode_entry(input mode_e m);
        entry_t e;
        e.state = S_OFF;
        e.duty  = '0;
        case (m)
            MODE_BLINK: e.state = S_BLINK;
            MODE_FADE:  e.state = S_UP;
            MODE_HOLD: begin
                e.state = S_HOLD;
                e.duty  = DUTY_FULL;
            end
            default: ;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/led_fader_pwm_gen.sv
// Free-running 256-cycle PWM counter with registered true/complementary comparators.
module pwm_gen
    import led_fader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] duty,
    input  logic              enable,
    output logic [1:0]        led
);

    logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [1:0]        led_q, led_d;
    logic [DUTY_W-1:0] cnt_ext;
    logic [DUTY_W-1:0] inv_duty;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        cnt_ext   = {1'b0, pwm_cnt_q};
        inv_duty  = DUTY_FULL - duty;
        led_d     = '0;
        if (enable) begin
            led_d[0] = (cnt_ext < duty);
            led_d[1] = (cnt_ext < inv_duty);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            led_q     <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/led_fader.sv
// LED fader: mode-driven duty sequencer (off, blink, triangular fade, full hold) feeding a PWM generator.
module led_fader
    import led_fader_pkg::*;
#(
    parameter int unsigned STEP       = 16,
    parameter int unsigned HOLD_TICKS = 2
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       tick,
    input  logic [1:0] mode,
    output logic [1:0] LED,
    output logic [2:0] phase,
    output logic       cycle_done
);

    localparam logic [CALC_W-1:0] STEP_C    = CALC_W'(STEP);
    localparam logic [CALC_W-1:0] FULL_C    = CALC_W'(DUTY_FULL);
    localparam logic [7:0]        HOLD_LAST = 8'(HOLD_TICKS - 1);

    mode_e             mode_in;
    mode_e             mode_q, mode_d;
    state_e            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [7:0]        hold_q, hold_d;
    logic              done_q, done_d;
    logic [CALC_W-1:0] up_sum;
    logic [CALC_W-1:0] dn_diff;
    entry_t            entry;
    logic              pwm_en;

    always_comb begin
        mode_in = mode_e'(mode);
        entry   = mode_entry(mode_in);
        mode_d  = mode_in;
        state_d = state_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        // Widened so a full-scale step cannot wrap; the sign bit of dn_diff flags undershoot.
        up_sum  = CALC_W'(duty_q) + STEP_C;
        dn_diff = CALC_W'(duty_q) - STEP_C;

        if (mode_in != mode_q) begin
            state_d = entry.state;
            duty_d  = entry.duty;
            hold_d  = '0;
        end else if (tick) begin
            case (state_q)
                S_BLINK: duty_d = (duty_q == '0) ? DUTY_FULL : '0;
                S_UP: begin
                    if (up_sum >= FULL_C) begin
                        duty_d  = DUTY_FULL;
                        state_d = S_HOLD_HI;
                        hold_d  = '0;
                    end else begin
                        duty_d = up_sum[DUTY_W-1:0];
                    end
                end
                S_DOWN: begin
                    if (dn_diff[CALC_W-1] || (dn_diff == '0)) begin
                        duty_d  = '0;
                        state_d = S_HOLD_LO;
                        hold_d  = '0;
                    end else begin
                        duty_d = dn_diff[DUTY_W-1:0];
                    end
                end
                S_HOLD_HI, S_HOLD_LO: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        if (state_q == S_HOLD_HI) begin
                            state_d = S_DOWN;
                        end else begin
                            state_d = S_UP;
                            done_d  = 1'b1;
                        end
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            mode_q  <= MODE_OFF;
            state_q <= S_OFF;
            duty_q  <= '0;
            hold_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            state_q <= state_d;
            duty_q  <= duty_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

    assign pwm_en = (state_q != S_OFF);

    pwm_gen u_pwm (
        .clk    (CLOCK_50),
        .rst_n  (RESET_N),
        .duty   (duty_q),
        .enable (pwm_en),
        .led    (LED)
    );

    assign phase      = state_q;
    assign cycle_done = done_q;

endmodule

// File: tb/tb_led_fader.sv
// Directed self-checking bench for led_fader: reset, fade sequence, PWM duty, blink, hold and saturation.
module tb_led_fader;
    import led_fader_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [1:0] mode;
    logic [1:0] led, led_s;
    logic [2:0] phase, phase_s;
    logic       done, done_s;

    int n_tests = 0;
    int n_fail  = 0;

    int          sat_duty  [10] = '{100, 200, 256, 256, 256, 156, 56, 0, 0, 0};
    logic [2:0]  sat_state [10] = '{S_UP, S_UP, S_HOLD_HI, S_HOLD_HI, S_DOWN,
                                    S_DOWN, S_DOWN, S_HOLD_LO, S_HOLD_LO, S_UP};

    led_fader dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .tick       (tick),
        .mode       (mode),
        .LED        (led),
        .phase      (phase),
        .cycle_done (done)
    );

    led_fader #(.STEP(100), .HOLD_TICKS(2)) dut_sat (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .tick       (tick),
        .mode       (mode),
        .LED        (led_s),
        .phase      (phase_s),
        .cycle_done (done_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    function automatic logic [2:0] fade_state(input int k);
        if (k < 16)      return S_UP;
        else if (k < 18) return S_HOLD_HI;
        else if (k < 34) return S_DOWN;
        else if (k < 36) return S_HOLD_LO;
        else             return S_UP;
    endfunction

    function automatic int fade_duty(input int k);
        if (k < 16)       return 16 * k;
        else if (k <= 18) return 256;
        else if (k < 34)  return 256 - 16 * (k - 18);
        else              return 0;
    endfunction

    initial begin
        int ones0, ones1, match;
        logic [1:0] exp_led;

        rst_n = 1'b0;
        tick  = 1'b0;
        mode  = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_led",   32'(led), 0);
        check("reset_phase", 32'(phase), S_OFF);
        check("reset_done",  32'(done), 0);
        check("reset_duty",  32'(dut.duty_q), 0);

        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("off_phase", 32'(phase), S_OFF);
        check("off_led",   32'(led), 0);

        // Fade: full triangle on the default instance, saturation on the STEP=100 one.
        mode = 2'b10;
        @(negedge clk);
        check("fade_entry_phase", 32'(phase), S_UP);
        check("fade_entry_duty",  32'(dut.duty_q), 0);
        for (int k = 1; k <= 36; k++) begin
            pulse_tick();
            check($sformatf("fade_phase_%0d", k), 32'(phase), 32'(fade_state(k)));
            check($sformatf("fade_duty_%0d", k),  32'(dut.duty_q), 32'(fade_duty(k)));
            check($sformatf("fade_done_%0d", k),  32'(done), (k == 36) ? 1 : 0);
            if (k <= 10) begin
                check($sformatf("sat_duty_%0d", k),  32'(dut_sat.duty_q), 32'(sat_duty[k-1]));
                check($sformatf("sat_phase_%0d", k), 32'(phase_s), 32'(sat_state[k-1]));
            end
        end
        @(negedge clk);
        check("fade_done_clears", 32'(done), 0);

        // Duty 128 from S_UP after 8 steps, then one full PWM period.
        for (int k = 0; k < 8; k++) pulse_tick();
        check("pwm_duty128", 32'(dut.duty_q), 128);
        @(negedge clk);
        ones0 = 0;
        ones1 = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            ones0 += int'(led[0]);
            ones1 += int'(led[1]);
        end
        check("pwm128_led0_high", 32'(ones0), 128);
        check("pwm128_led1_high", 32'(ones1), 128);

        // Asynchronous reset mid-fade, away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("midreset_led",   32'(led), 0);
        check("midreset_phase", 32'(phase), S_OFF);
        check("midreset_duty",  32'(dut.duty_q), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postreset_phase", 32'(phase), S_UP);
        check("postreset_duty",  32'(dut.duty_q), 0);

        // Mode change to HOLD coinciding with a tick: no fade step applied.
        pulse_tick();
        pulse_tick();
        check("prehold_duty", 32'(dut.duty_q), 32);
        mode = 2'b11;
        pulse_tick();
        check("hold_phase", 32'(phase), S_HOLD);
        check("hold_duty",  32'(dut.duty_q), 256);
        for (int k = 0; k < 3; k++) pulse_tick();
        check("hold_phase_ticks", 32'(phase), S_HOLD);
        check("hold_duty_ticks",  32'(dut.duty_q), 256);
        ones0 = 0;
        ones1 = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            ones0 += int'(led[0]);
            ones1 += int'(led[1]);
        end
        check("pwm256_led0_high", 32'(ones0), 256);
        check("pwm256_led1_high", 32'(ones1), 0);

        // Blink: duty toggles 256,0,256,0 with LED held per full period.
        mode = 2'b01;
        @(negedge clk);
        check("blink_entry_phase", 32'(phase), S_BLINK);
        check("blink_entry_duty",  32'(dut.duty_q), 0);
        for (int k = 1; k <= 4; k++) begin
            pulse_tick();
            check($sformatf("blink_duty_%0d", k), 32'(dut.duty_q), (k % 2 == 1) ? 256 : 0);
            exp_led = (k % 2 == 1) ? 2'b01 : 2'b10;
            match = 0;
            for (int i = 0; i < 256; i++) begin
                @(negedge clk);
                if (led == exp_led) match++;
            end
            check($sformatf("blink_led_period_%0d", k), 32'(match), 256);
        end

        // Back to OFF: ticks ignored, LEDs dark.
        mode = 2'b00;
        @(negedge clk);
        check("off2_phase", 32'(phase), S_OFF);
        check("off2_duty",  32'(dut.duty_q), 0);
        pulse_tick();
        pulse_tick();
        check("off2_phase_ticks", 32'(phase), S_OFF);
        check("off2_duty_ticks",  32'(dut.duty_q), 0);
        check("off2_led",         32'(led), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_fader.md
LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 The block SHALL have parameter STEP, default 16, meaning the duty increment/decrement applied per tick in fade mode, legal range 1..256.
REQ-002 The block SHALL have parameter HOLD_TICKS, default 2, meaning the number of ticks spent in each fade hold state, legal range 1..255.
REQ-003 The block SHALL have port CLOCK_50  input  1  the single system clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port RESET_N  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port tick  input  1  single-cycle pulse from the upstream blink timer.
REQ-006 The block SHALL have port mode  input  2  operating mode: 00 OFF, 01 BLINK, 10 FADE, 11 HOLD.
REQ-007 The block SHALL have port LED  output  2  registered PWM LED drives: LED[0] true duty, LED[1] complementary duty.
REQ-008 The block SHALL have port phase  output  3  current state encoding.
REQ-009 The block SHALL have port cycle_done  output  1  one-cycle pulse marking completion of each full fade cycle.

Function
REQ-010 The block SHALL keep an 8-bit free-running pwm_cnt that increments every cycle and wraps from 255 to 0, giving a 256-cycle PWM period.
REQ-011 The block SHALL keep a 9-bit duty register in the range 0..256.
REQ-012 The block SHALL register LED[0] as ({0,pwm_cnt} < duty) and LED[1] as ({0,pwm_cnt} < 256-duty), with one cycle of latency, except in S_OFF where both are 0.
REQ-013 The block SHALL implement the states S_OFF, S_BLINK, S_UP, S_HOLD_HI, S_DOWN, S_HOLD_LO and S_HOLD.
REQ-014 The block SHALL register mode into mode_q each cycle and treat mode != mode_q as a mode change.
REQ-015 On a mode change, the block SHALL enter the following state and duty on the next cycle:
- OFF: S_OFF, duty 0.
- BLINK: S_BLINK, duty 0.
- FADE: S_UP, duty 0.
- HOLD: S_HOLD, duty 256.
REQ-016 When a mode change and a tick coincide, the mode change SHALL win and the tick SHALL be ignored.
REQ-017 In S_BLINK, each tick SHALL toggle duty between 0 and 256.
REQ-018 In S_UP, each tick SHALL set duty to min(duty+STEP, 256); when the result is 256 the block SHALL go to S_HOLD_HI with hold_cnt 0.
REQ-019 In S_HOLD_HI and S_HOLD_LO, each tick SHALL increment hold_cnt; on the tick where hold_cnt == HOLD_TICKS-1, the block SHALL clear hold_cnt and advance (S_HOLD_HI to S_DOWN, S_HOLD_LO to S_UP).
REQ-020 In S_DOWN, each tick SHALL set duty to max(duty-STEP, 0), saturating without underflow; when the result is 0 the block SHALL go to S_HOLD_LO.
REQ-021 On the S_HOLD_LO to S_UP transition, the block SHALL assert cycle_done for exactly one cycle, registered.
REQ-022 In S_OFF and S_HOLD, tick SHALL be ignored.
REQ-023 Duty arithmetic SHALL be performed at 10 bits internally so that no intermediate value wraps.

Reset
REQ-024 While RESET_N is low, the block SHALL immediately force: pwm_cnt 0, duty 0, hold_cnt 0, state S_OFF, mode_q OFF, LED 00, phase S_OFF, cycle_done 0.
REQ-025 Reset asserted mid-fade SHALL abort the fade with no residual state.
REQ-026 After reset release with mode held at a non-OFF value, the block SHALL detect a mode change on the first clock edge.

Structure
REQ-027 The mode encodings, the state encodings (3-bit, S_OFF = 0) and the PWM width constant SHALL reside in the shared package led_fader_pkg.
REQ-028 The PWM counter and comparator pair SHALL be a sub-module pwm_gen (inputs duty and enable, output 2-bit LED), instantiated once.

Verification
REQ-029 Reset: assert RESET_N=0 mid-fade with duty 128 -> LED=00, phase=S_OFF and duty=0 immediately; after release with mode=10 -> S_UP on the next edge.
REQ-030 Fade (STEP=16, HOLD_TICKS=2): 36 ticks -> the sequence is 16 ticks S_UP, 2 S_HOLD_HI, 16 S_DOWN, 2 S_HOLD_LO; cycle_done pulses once, after the 36th tick.
REQ-031 PWM: with duty held at 128 -> LED[0] high for exactly 128 of each 256 cycles and LED[1] high for the other 128; with duty 256 -> LED[0] constantly 1 and LED[1] constantly 0.
REQ-032 Blink: mode=01 with 4 ticks -> duty sequence 256, 0, 256, 0, and LED alternates between 01 and 10 over full PWM periods.
REQ-033 Simultaneous events: mode change 10->11 coinciding with a tick -> S_HOLD with duty 256 and no fade step applied; subsequent ticks cause no change.
REQ-034 Saturation: STEP=100 -> up-ramp duty sequence 100, 200, 256; down-ramp duty sequence 156, 56, 0; no wrap at any step.
